contador_parametrizado: RTL and testbench

CONTADOR_PARAMETRIZADO -- requirements
Module: contador_parametrizado

---
 rtl/contador_parametrizado.sv | 77 +++++++
 tb/tb_contador_parametrizado.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/contador_parametrizado.sv
// Parameterised up/down modulo counter with parallel load, saturate-or-wrap boundary
// handling, a combinational terminal count, a registered wrap pulse and a sticky overflow flag.
module contador_parametrizado #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             t,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             ovf_next;

  assign at_top = (q == MAX_VAL);
  assign at_bot = (q == '0);
  assign tc     = t & ((up & at_top) | (~up & at_bot));

  // Load wins over counting; an out-of-range load value is clamped so q stays below MODULO.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    ovf_next  = ovf;
    if (load) begin
      q_next   = (d > MAX_VAL) ? MAX_VAL : d;
      ovf_next = 1'b0;
    end else if (t) begin
      if (up) begin
        if (at_top) begin
          ovf_next = 1'b1;
          if (!sat) begin
            q_next    = '0;
            wrap_next = 1'b1;
          end
        end else begin
          q_next = q + 1'b1;
        end
      end else begin
        if (at_bot) begin
          ovf_next = 1'b1;
          if (!sat) begin
            q_next    = MAX_VAL;
            wrap_next = 1'b1;
          end
        end else begin
          q_next = q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_contador_parametrizado.sv
// Directed self-checking bench for contador_parametrizado at WIDTH=4, MODULO=10.
module tb_contador_parametrizado;

  logic       clk;
  logic       clr;
  logic       t;
  logic       up;
  logic       sat;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic       ovf;

  int checkCount;
  int failCount;

  contador_parametrizado #(.WIDTH(4), .MODULO(10)) dut (
    .clk (clk),
    .clr (clr),
    .t   (t),
    .up  (up),
    .sat (sat),
    .load(load),
    .d   (d),
    .q   (q),
    .tc  (tc),
    .wrap(wrap),
    .ovf (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [3:0] dv, input logic tv,
                               input logic uv, input logic sv);
    load = l;
    d    = dv;
    t    = tv;
    up   = uv;
    sat  = sv;
    #1;
  endtask

  // Inputs change and outputs are sampled around the falling edge, away from the active edge.
  task automatic stepClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkState(input string tag, input logic [3:0] eq, input logic ew, input logic eo);
    checkOutput({tag, ".q"}, 32'(q), 32'(eq));
    checkOutput({tag, ".wrap"}, 32'(wrap), 32'(ew));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    clr = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    #2;
    checkState("reset", 4'd0, 1'b0, 1'b0);
    checkOutput("reset.tc_t0", 32'(tc), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset.tc_down", 32'(tc), 32'd1);
    stepClock();
    checkOutput("reset.hold_q", 32'(q), 32'd0);

    // Up wrap: 0..9,0,1 with a single wrap pulse and ovf sticky from the wrap on
    clr = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      checkOutput($sformatf("upwrap.tc%0d", k), 32'(tc), ((k - 1) % 10 == 9) ? 32'd1 : 32'd0);
      stepClock();
      checkState($sformatf("upwrap%0d", k), 4'(k % 10), (k == 10), (k >= 10));
    end

    // Down saturate from a loaded 2
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    stepClock();
    checkState("dsat.load", 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    stepClock(); checkState("dsat1", 4'd1, 1'b0, 1'b0);
    stepClock(); checkState("dsat2", 4'd0, 1'b0, 1'b0);
    stepClock(); checkState("dsat3", 4'd0, 1'b0, 1'b1);
    stepClock(); checkState("dsat4", 4'd0, 1'b0, 1'b1);

    // Count up to 5 with ovf still set, then clamp-load with t=1
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) stepClock();
    checkState("pre_clamp", 4'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    stepClock();
    checkState("clamp", 4'd9, 1'b0, 1'b0);

    // Boundary event coinciding with load: load wins, ovf cleared, tc ignores load
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("bload.tc", 32'(tc), 32'd1);
    stepClock();
    checkState("bload", 4'd3, 1'b0, 1'b0);

    // Up saturate at 9
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b1, 1'b1);
    stepClock();
    checkState("usat.load", 4'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    stepClock();
    checkState("usat", 4'd9, 1'b0, 1'b1);

    // Down wrap from 0 to 9, pulse lasts a single cycle
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkState("dwrap", 4'd9, 1'b1, 1'b1);
    stepClock();
    checkState("dwrap.next", 4'd8, 1'b0, 1'b1);

    // Hold at 7 with up toggling
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    stepClock();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'(k % 2), 1'b0);
      checkOutput($sformatf("hold.tc%0d", k), 32'(tc), 32'd0);
      stepClock();
      checkState($sformatf("hold%0d", k), 4'd7, 1'b0, 1'b0);
    end

    // Direction flip at the top boundary
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("flip.tc_up", 32'(tc), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("flip.tc_down", 32'(tc), 32'd0);
    stepClock();
    checkState("flip", 4'd8, 1'b0, 1'b0);

    // Asynchronous reset mid-count at q=6 with ovf set, then resume from 0
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) stepClock();
    checkState("pre_areset", 4'd6, 1'b0, 1'b1);
    #2;
    clr = 1'b0;
    #1;
    checkState("areset", 4'd0, 1'b0, 1'b0);
    stepClock();
    checkState("areset.held", 4'd0, 1'b0, 1'b0);
    clr = 1'b1;
    stepClock();
    checkState("resume", 4'd1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
